// File: rtl/tetris_pkg.sv
// tetris_pkg: shared board geometry, line-clear FSM states and line-clear score table.
package tetris_pkg;
    localparam int DEF_ROWS = 20;
    localparam int DEF_COLS = 10;
    typedef enum logic [1:0] {IDLE, SCAN, SETTLE, DONE} clr_state_t;
    localparam logic [10:0] SCORE_0 = 11'd0;
    localparam logic [10:0] SCORE_1 = 11'd40;
    localparam logic [10:0] SCORE_2 = 11'd100;
    localparam logic [10:0] SCORE_3 = 11'd300;
    localparam logic [10:0] SCORE_4 = 11'd1200;
    function automatic logic [10:0] score_for(input int unsigned n);
        return n >= 4 ? SCORE_4 : n == 3 ? SCORE_3 : n == 2 ? SCORE_2 : n == 1 ? SCORE_1 : SCORE_0;
    endfunction
endpackage

// File: rtl/line_clear_ctrl_if.sv
// line_clear_ctrl_if: board/shift and pass-control signals between game side and line_clear_ctrl.
interface line_clear_ctrl_if #(
    parameter int ROWS = tetris_pkg::DEF_ROWS,
    parameter int COLS = tetris_pkg::DEF_COLS
);
    logic                         start;
    logic [ROWS*COLS-1:0]         board;
    logic [ROWS-1:0]              shift_row;
    logic                         busy;
    logic                         done;
    logic [$clog2(ROWS+1)-1:0]    lines_cleared;
    logic [23:0]                  score;
    modport master (output start, board, input shift_row, busy, done, lines_cleared, score);
    modport slave  (input start, board, output shift_row, busy, done, lines_cleared, score);
endinterface

// File: rtl/line_clear_ctrl_score_accum.sv
// score_accum: accumulator that adds value on each add pulse, saturating at all ones.
module score_accum #(
    parameter int W  = 24,
    parameter int VW = 11
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          add,
    input  logic [VW-1:0] value,
    output logic [W-1:0]  sum
);
    logic [W:0] nxt;
    assign nxt = {1'b0, sum} + (W+1)'(value);
    always_ff @(posedge clk or negedge reset)
        if (!reset) sum <= '0;
        else if (add) sum <= nxt[W] ? '1 : nxt[W-1:0];
endmodule

// File: rtl/line_clear_ctrl.sv
// line_clear_ctrl: bottom-up full-row scan that drives per-row shift enables, one cleared line at a time.
// Optional score accumulation is compiled in when LINE_CLEAR_SCORE_EN is defined.
module line_clear_ctrl
    import tetris_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS
) (
    input logic               clk,
    input logic               reset,
    line_clear_ctrl_if.slave  bus
);
    localparam int IW = $clog2(ROWS);
    localparam int CW = $clog2(ROWS+1);
    clr_state_t      state;
    logic [IW-1:0]   idx;
    logic [CW-1:0]   count;
    logic [CW-1:0]   lines_q;
    logic [ROWS-1:0] shift_q;
    logic            full;
    logic [ROWS-1:0] mask;
    assign full = &bus.board[int'(idx)*COLS +: COLS];
    // rows 0..idx all move down by one
    assign mask = {ROWS{1'b1}} >> (ROWS - 1 - int'(idx));
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state   <= IDLE;
            idx     <= '0;
            count   <= '0;
            lines_q <= '0;
            shift_q <= '0;
        end else begin
            shift_q <= '0;
            case (state)
                IDLE: if (bus.start) begin
                    idx   <= IW'(ROWS - 1);
                    count <= '0;
                    state <= SCAN;
                end
                SCAN: if (full) begin
                    shift_q <= mask;
                    count   <= count + 1'b1;
                    state   <= SETTLE;
                end else if (idx == '0) state <= DONE;
                else idx <= idx - 1'b1;
                SETTLE: state <= SCAN;
                DONE: begin
                    lines_q <= count;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    assign bus.shift_row     = shift_q;
    assign bus.busy          = state == SCAN || state == SETTLE;
    assign bus.done          = state == DONE;
    assign bus.lines_cleared = lines_q;
`ifdef LINE_CLEAR_SCORE_EN
    logic [23:0] score_q;
    score_accum #(.W(24), .VW(11)) u_score (
        .clk   (clk),
        .reset (reset),
        .add   (state == DONE),
        .value (score_for(int'(count))),
        .sum   (score_q)
    );
    assign bus.score = score_q;
`else
    assign bus.score = '0;
`endif
endmodule

// File: tb/tb_line_clear_ctrl.sv
// tb_line_clear_ctrl: table-driven passes with a scoreboard plus busy-start and mid-SETTLE reset sequences.
module tb_line_clear_ctrl;
    localparam int ROWS = 20;
    localparam int COLS = 10;
    localparam int BW   = ROWS * COLS;

    typedef struct {
        logic [BW-1:0]   b;
        int              lines;
        logic [ROWS-1:0] m0;
        logic [ROWS-1:0] m1;
        bit              extra_start;
    } vec_t;

    typedef struct {
        int            lines;
        logic [23:0]   score;
        int            cycles;
        logic [BW-1:0] fin;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic load = 1'b0;
    logic [BW-1:0] load_val = '0;
    logic [BW-1:0] rows = '0;
    logic [23:0] model_score = '0;
    int total = 0;
    int passed = 0;
    exp_t sbq[$];
    vec_t vt[7];

    line_clear_ctrl_if #(.ROWS(ROWS), .COLS(COLS)) bus ();
    line_clear_ctrl #(.ROWS(ROWS), .COLS(COLS)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;
    assign bus.board = rows;

    function automatic logic [BW-1:0] row(input int r, input logic [COLS-1:0] v);
        logic [BW-1:0] n = '0;
        n[r*COLS +: COLS] = v;
        return n;
    endfunction

    function automatic logic [BW-1:0] apply_shift(input logic [BW-1:0] b, input logic [ROWS-1:0] m);
        logic [BW-1:0] n = b;
        for (int r = 0; r < ROWS; r++)
            if (m[r]) begin
                if (r == 0) n[0 +: COLS] = '0;
                else n[r*COLS +: COLS] = b[(r-1)*COLS +: COLS];
            end
        return n;
    endfunction

    // Reference result: drop every full row and let the rest fall, zero-filling the top.
    function automatic logic [BW-1:0] ref_clear(input logic [BW-1:0] b);
        logic [BW-1:0] n = '0;
        int w = ROWS - 1;
        for (int r = ROWS - 1; r >= 0; r--)
            if (~&b[r*COLS +: COLS]) begin
                n[w*COLS +: COLS] = b[r*COLS +: COLS];
                w--;
            end
        return n;
    endfunction

    function automatic longint pts(input int l);
        return l >= 4 ? 1200 : l == 3 ? 300 : l == 2 ? 100 : l == 1 ? 40 : 0;
    endfunction

    always @(posedge clk)
        if (load) rows <= load_val;
        else rows <= apply_shift(rows, bus.shift_row);

    task automatic check(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else passed++;
    endtask

    task automatic run_pass(input int id, input vec_t v);
        exp_t e;
        int cyc;
        int extra;
        logic [ROWS-1:0] masks[$];
        @(negedge clk);
        load_val = v.b;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        e.lines  = v.lines;
        e.cycles = ROWS + 2 * v.lines + 1;
        e.fin    = ref_clear(v.b);
`ifdef LINE_CLEAR_SCORE_EN
        model_score = (longint'(model_score) + pts(v.lines) > 64'hFFFFFF) ? 24'hFFFFFF
                    : 24'(longint'(model_score) + pts(v.lines));
`endif
        e.score = model_score;
        sbq.push_back(e);
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            bus.start = (cyc == 0) || (v.extra_start && (cyc == 6 || cyc == 7));
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 1) check($sformatf("v%0d busy_rise", id), bus.busy, 1);
            if (bus.shift_row != '0) masks.push_back(bus.shift_row);
        end
        @(negedge clk);
        bus.start = 1'b0;
        e = sbq.pop_front();
        check($sformatf("v%0d done_cycle", id), cyc, e.cycles);
        check($sformatf("v%0d busy_in_done", id), bus.busy, 0);
        @(posedge clk);
        #1;
        check($sformatf("v%0d done_pulse", id), bus.done, 0);
        check($sformatf("v%0d lines", id), bus.lines_cleared, e.lines);
        check($sformatf("v%0d score", id), bus.score, e.score);
        check($sformatf("v%0d board", id), rows, e.fin);
        check($sformatf("v%0d shift_cycles", id), masks.size(), e.lines);
        if (v.m0 != '0) check($sformatf("v%0d mask0", id), masks.size() > 0 ? masks[0] : '0, v.m0);
        if (v.m1 != '0) check($sformatf("v%0d mask1", id), masks.size() > 1 ? masks[1] : '0, v.m1);
        extra = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) extra++;
        end
        check($sformatf("v%0d no_extra_done", id), extra, 0);
    endtask

    initial begin
        int k;
        bus.start = 1'b0;
        vt[0] = '{'0, 0, '0, '0, 1'b0};
        vt[1] = '{row(19, 10'h3FF) | row(18, 10'h155), 1, 20'hFFFFF, '0, 1'b0};
        vt[2] = '{row(19, 10'h3FF) | row(18, 10'h3FF) | row(17, 10'h3FF) | row(16, 10'h3FF),
                  4, 20'hFFFFF, 20'hFFFFF, 1'b1};
        vt[3] = '{row(19, 10'h3FF) | row(18, 10'h2AA) | row(17, 10'h3FF) | row(16, 10'h0F0),
                  2, 20'hFFFFF, 20'h7FFFF, 1'b0};
        vt[4] = '{row(5, 10'h3FF) | row(0, 10'h3FF) | row(10, 10'h3FE), 2, 20'h0003F, 20'h00003, 1'b0};
        vt[5] = '{row(0, 10'h3FF), 1, 20'h00001, '0, 1'b0};
        vt[6] = '{row(19, 10'h3FF) | row(18, 10'h001) | row(17, 10'h3FF) | row(15, 10'h3FF)
                  | row(13, 10'h3FF) | row(12, 10'h200) | row(11, 10'h3FF), 5, 20'hFFFFF, 20'h7FFFF, 1'b0};
        repeat (3) @(posedge clk);
        #1;
        check("rst shift_row", bus.shift_row, 0);
        check("rst busy", bus.busy, 0);
        check("rst done", bus.done, 0);
        check("rst lines", bus.lines_cleared, 0);
        check("rst score", bus.score, 0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 7; i++) run_pass(i, vt[i]);
        @(negedge clk);
        load_val = row(19, 10'h3FF);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        k = 0;
        while (bus.shift_row == '0 && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("settle_reached", bus.shift_row != '0, 1);
        #2 reset = 1'b0;
        #1;
        check("midrst shift_row", bus.shift_row, 0);
        check("midrst busy", bus.busy, 0);
        check("midrst done", bus.done, 0);
        check("midrst lines", bus.lines_cleared, 0);
        check("midrst score", bus.score, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_after_rst busy", bus.busy, 0);
        check("idle_after_rst done", bus.done, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
